// File: rtl/mips_regfile_sb_if.sv
// rtl/mips_regfile_sb_if.sv - decode/write-back bus for the MIPS register file with scoreboard
//
// Signals (master = decode/write-back side, slave = register file):
//   we, waddr, wdata       write port, sampled on rising clk
//   raddr1, raddr2         read port addresses
//   rdata1, rdata2         combinational read data (with write bypass)
//   busy1, busy2           combinational outstanding-producer flags for raddr1/raddr2
//   claim, claim_addr      mark a register busy for an issued producer
//   busy_cnt               registered number of busy registers
interface mips_regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              busy1;
    logic              busy2;
    logic              claim;
    logic [ADDR_W-1:0] claim_addr;
    logic [ADDR_W:0]   busy_cnt;

    modport master (
        output we, waddr, wdata, raddr1, raddr2, claim, claim_addr,
        input  rdata1, rdata2, busy1, busy2, busy_cnt
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2, claim, claim_addr,
        output rdata1, rdata2, busy1, busy2, busy_cnt
    );
endinterface

// File: rtl/mips_regfile_sb.sv
// rtl/mips_regfile_sb.sv - MIPS register file with write bypass and busy scoreboard
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears registers, busy bits and busy_cnt
//   bus    mips_regfile_sb_if.slave: write port, two combinational read ports,
//          per-port busy flags, claim port and registered busy count
// Parameters:
//   DATA_W   register width
//   ADDR_W   address width, 2**ADDR_W registers
//   ZERO_REG 1: register 0 is hardwired zero, never written, never busy
module mips_regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    mips_regfile_sb_if.slave    bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;
    logic [ADDR_W:0]   cnt_next;
    logic [ADDR_W:0]   busy_cnt_q;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    // A write to the zero register is dropped entirely, including its bypass.
    logic wr_ok;
    assign wr_ok = bus.we && !is_zero(bus.waddr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_ok) begin
            regs[bus.waddr] <= bus.wdata;
        end
    end

    // Claim beats a same-cycle write to the same register: the claiming
    // instruction is a newer producer than the one completing now.
    always_comb begin
        busy_next = busy;
        cnt_next  = '0;
        for (int r = 0; r < DEPTH; r++) begin
            if (bus.claim && bus.claim_addr == ADDR_W'(r) && !is_zero(ADDR_W'(r))) begin
                busy_next[r] = 1'b1;
            end else if (bus.we && bus.waddr == ADDR_W'(r)) begin
                busy_next[r] = 1'b0;
            end
            cnt_next = cnt_next + (ADDR_W + 1)'(busy_next[r]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy       <= busy_next;
            busy_cnt_q <= cnt_next;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
        if (is_zero(ra)) begin
            return '0;
        end else if (wr_ok && bus.waddr == ra) begin
            return bus.wdata;
        end else begin
            return regs[ra];
        end
    endfunction

    // A completing write releases the stall in its own cycle unless the same
    // register is being re-claimed in that cycle.
    function automatic logic busy_port(input logic [ADDR_W-1:0] ra);
        logic completing;
        completing = bus.we && bus.waddr == ra && !(bus.claim && bus.claim_addr == ra);
        return busy[ra] && !completing;
    endfunction

    assign bus.rdata1   = read_port(bus.raddr1);
    assign bus.rdata2   = read_port(bus.raddr2);
    assign bus.busy1    = busy_port(bus.raddr1);
    assign bus.busy2    = busy_port(bus.raddr2);
    assign bus.busy_cnt = busy_cnt_q;
endmodule

// File: tb/tb_mips_regfile_sb.sv
// tb/tb_mips_regfile_sb.sv - self-checking bench for mips_regfile_sb
module tb_mips_regfile_sb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips_regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    mips_regfile_sb_if #(.DATA_W(16), .ADDR_W(3)) pbus ();

    mips_regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    mips_regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (pbus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr1;
        logic [4:0]  raddr2;
        logic        claim;
        logic [4:0]  claim_addr;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_b1;
        logic        e_b2;
        logic [5:0]  e_cnt;
    } vec_t;

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        b1;
        logic        b2;
        logic [5:0]  cnt;
    } exp_t;

    vec_t vecs [14];
    exp_t sb_q [$];

    task automatic drive_idle();
        bus.we = 0; bus.waddr = 0; bus.wdata = 0; bus.raddr1 = 0; bus.raddr2 = 0;
        bus.claim = 0; bus.claim_addr = 0;
    endtask

    initial begin
        exp_t e;
        drive_idle();
        pbus.we = 0; pbus.waddr = 0; pbus.wdata = 0; pbus.raddr1 = 0; pbus.raddr2 = 0;
        pbus.claim = 0; pbus.claim_addr = 0;

        //            we wa  wdata         r1  r2 cl ca   e_rd1         e_rd2         b1 b2 cnt
        vecs[0]  = '{0, 0,  32'h0,        0,  1, 0, 0,  32'h0,        32'h0,        0, 0, 0};
        vecs[1]  = '{1, 9,  32'h12345678, 9,  3, 0, 0,  32'h12345678, 32'h0,        0, 0, 0};
        vecs[2]  = '{0, 0,  32'h0,        9,  9, 0, 0,  32'h12345678, 32'h12345678, 0, 0, 0};
        vecs[3]  = '{1, 0,  32'hFFFFFFFF, 0,  9, 1, 0,  32'h0,        32'h12345678, 0, 0, 0};
        vecs[4]  = '{0, 0,  32'h0,        0,  8, 1, 8,  32'h0,        32'h0,        0, 0, 1};
        vecs[5]  = '{0, 0,  32'h0,        8,  0, 1, 8,  32'h0,        32'h0,        1, 0, 1};
        vecs[6]  = '{1, 8,  32'hA5,       8,  8, 0, 0,  32'hA5,       32'hA5,       0, 0, 0};
        vecs[7]  = '{0, 0,  32'h0,        8,  9, 0, 0,  32'hA5,       32'h12345678, 0, 0, 0};
        vecs[8]  = '{0, 0,  32'h0,        10, 8, 1, 10, 32'h0,        32'hA5,       0, 0, 1};
        vecs[9]  = '{1, 10, 32'h77,       10, 10, 1, 10, 32'h77,      32'h77,       1, 1, 1};
        vecs[10] = '{0, 0,  32'h0,        10, 11, 0, 0, 32'h77,       32'h0,        1, 0, 1};
        vecs[11] = '{1, 10, 32'h99,       10, 12, 1, 12, 32'h99,      32'h0,        0, 0, 1};
        vecs[12] = '{0, 0,  32'h0,        12, 10, 0, 0, 32'h0,        32'h99,       1, 0, 1};
        vecs[13] = '{1, 12, 32'h5,        13, 12, 0, 0, 32'h0,        32'h5,        0, 0, 0};

        // Reset state while rst_n is still low
        repeat (2) @(posedge clk);
        #1;
        check("reset_cnt", 32'(bus.busy_cnt), 32'h0);
        check("reset_rd1", bus.rdata1, 32'h0);
        check("reset_busy1", 32'(bus.busy1), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors through the scoreboard queue
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            bus.we = vecs[i].we; bus.waddr = vecs[i].waddr; bus.wdata = vecs[i].wdata;
            bus.raddr1 = vecs[i].raddr1; bus.raddr2 = vecs[i].raddr2;
            bus.claim = vecs[i].claim; bus.claim_addr = vecs[i].claim_addr;
            sb_q.push_back('{vecs[i].e_rd1, vecs[i].e_rd2, vecs[i].e_b1, vecs[i].e_b2, vecs[i].e_cnt});
            #2;
            e = sb_q.pop_front();
            check($sformatf("v%0d_rd1", i), bus.rdata1, e.rd1);
            check($sformatf("v%0d_rd2", i), bus.rdata2, e.rd2);
            check($sformatf("v%0d_b1", i), 32'(bus.busy1), 32'(e.b1));
            check($sformatf("v%0d_b2", i), 32'(bus.busy2), 32'(e.b2));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_cnt", i), 32'(bus.busy_cnt), 32'(e.cnt));
        end

        // Asynchronous reset in the middle of a cycle
        @(negedge clk);
        drive_idle();
        bus.we = 1; bus.waddr = 5; bus.wdata = 32'hDEADBEEF; bus.claim = 1; bus.claim_addr = 6;
        @(negedge clk);
        drive_idle();
        bus.raddr1 = 5; bus.raddr2 = 6;
        #2;
        check("pre_rst_rd1", bus.rdata1, 32'hDEADBEEF);
        check("pre_rst_busy2", 32'(bus.busy2), 32'h1);
        check("pre_rst_cnt", 32'(bus.busy_cnt), 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_rst_rd1", bus.rdata1, 32'h0);
        check("async_rst_busy2", 32'(bus.busy2), 32'h0);
        check("async_rst_cnt", 32'(bus.busy_cnt), 32'h0);
        rst_n = 1'b1;

        // Narrow instance, register 0 ordinary
        @(negedge clk);
        pbus.we = 1; pbus.waddr = 0; pbus.wdata = 16'hBEEF;
        @(negedge clk);
        pbus.we = 0; pbus.raddr1 = 0;
        #2;
        check("p_reg0", 32'(pbus.rdata1), 32'hBEEF);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pbus.claim = 1; pbus.claim_addr = 3'(i);
        end
        @(negedge clk);
        pbus.claim = 0; pbus.raddr1 = 0; pbus.raddr2 = 7;
        #2;
        check("p_cnt_full", 32'(pbus.busy_cnt), 32'h8);
        check("p_busy_r0", 32'(pbus.busy1), 32'h1);
        check("p_busy_r7", 32'(pbus.busy2), 32'h1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pbus.we = 1; pbus.waddr = 3'(i); pbus.wdata = 16'(i * 16'h111);
        end
        @(negedge clk);
        pbus.we = 0; pbus.raddr1 = 3; pbus.raddr2 = 7;
        #2;
        check("p_cnt_empty", 32'(pbus.busy_cnt), 32'h0);
        check("p_rd_r3", 32'(pbus.rdata1), 32'h333);
        check("p_rd_r7", 32'(pbus.rdata2), 32'h777);
        check("p_busy_r3_clr", 32'(pbus.busy1), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
